// File: rtl/racer_pkg.sv
// Shared constants and types for the racer I/O front end: VGA timing, sprite geometry,
// colours, PS/2 scan codes and the key-decoder state type.
package racer_pkg;

  // 640x480@60 timing, in pixel clocks and lines
  localparam logic [9:0] HTotal     = 10'd800;
  localparam logic [9:0] HVisible   = 10'd640;
  localparam logic [9:0] HSyncStart = 10'd656;
  localparam logic [9:0] HSyncEnd   = 10'd752;
  localparam logic [9:0] VTotal     = 10'd525;
  localparam logic [9:0] VVisible   = 10'd480;
  localparam logic [9:0] VSyncStart = 10'd490;
  localparam logic [9:0] VSyncEnd   = 10'd492;

  // Sprite geometry is 11 bits wide so position + size cannot wrap
  localparam logic [10:0] CarW    = 11'd40;
  localparam logic [10:0] CarH    = 11'd60;
  localparam logic [10:0] PlayerY = 11'd400;
  localparam logic [10:0] Enemy1X = 11'd160;
  localparam logic [10:0] Enemy2X = 11'd360;
  localparam logic [10:0] RoadX   = 11'd100;
  localparam logic [10:0] RoadW   = 11'd440;

  localparam logic [23:0] ColPlayer = 24'hFF0000;
  localparam logic [23:0] ColEnemy1 = 24'h0000FF;
  localparam logic [23:0] ColEnemy2 = 24'hFFFF00;
  localparam logic [23:0] ColRoad   = 24'h404040;
  localparam logic [23:0] ColGrass  = 24'h00A000;

  localparam logic [7:0] ScanExt   = 8'hE0;
  localparam logic [7:0] ScanBreak = 8'hF0;
  localparam logic [7:0] ScanRight = 8'h74;
  localparam logic [7:0] ScanLeft  = 8'h6B;

  localparam logic [1:0] Led2None  = 2'b00;
  localparam logic [1:0] Led2Left  = 2'b10;
  localparam logic [1:0] Led2Right = 2'b11;

  typedef enum logic [1:0] {
    KeyIdle  = 2'd0,
    KeyExt   = 2'd1,
    KeyBreak = 2'd2
  } key_state_e;

  function automatic logic in_span(input logic [10:0] pos, input logic [10:0] lo,
                                   input logic [10:0] len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronises the raw lines, shifts in 11-bit frames on falling
// PS2CLK edges and emits a one-cycle valid pulse per good byte. Parity checked when
// RACER_PS2_PARITY_EN is defined.
module ps2_rx #(
  parameter int unsigned Timeout = 5000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] data_o,
  output logic       valid_o
);

  localparam int unsigned IdleW = $clog2(Timeout + 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(Timeout);

  logic [2:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic [3:0]       bit_cnt_q;
  logic [9:0]       shift_q;
  logic [10:0]      frame_q;
  logic             done_q;
  logic [IdleW-1:0] idle_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             ps2_fall;
  logic             frame_ok;

  assign ps2_fall = clk_sync_q[2] & ~clk_sync_q[1];

  // frame_q: [0] start, [8:1] data LSB first, [9] parity, [10] stop
`ifdef RACER_PS2_PARITY_EN
  assign frame_ok = ~frame_q[0] & frame_q[10] & (^frame_q[9:1]);
`else
  logic unused_parity;
  assign unused_parity = frame_q[9];
  assign frame_ok = ~frame_q[0] & frame_q[10];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_q     <= '0;
      done_q      <= 1'b0;
      idle_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      done_q      <= 1'b0;
      valid_q     <= done_q & frame_ok;
      if (done_q && frame_ok) begin
        data_q <= frame_q[8:1];
      end
      if (ps2_fall) begin
        idle_q <= '0;
        if (bit_cnt_q == 4'd10) begin
          frame_q   <= {data_sync_q[1], shift_q};
          done_q    <= 1'b1;
          bit_cnt_q <= '0;
        end else begin
          shift_q   <= {data_sync_q[1], shift_q[9:1]};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end else if (idle_q != IdleMax) begin
        idle_q <= idle_q + 1'b1;
      end else begin
        // Line idle too long: drop any partial frame
        bit_cnt_q <= '0;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/racer_io_frontend.sv
// Racer I/O front end: PS/2 steering decoder, 640x480 VGA sprite renderer and 1 Hz divider.
// Define RACER_PS2_PARITY_EN to drop PS/2 frames with bad (even) parity.
module racer_io_frontend
  import racer_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned PS2_TIMEOUT = 5000
) (
  input  logic       FPGACLK,
  input  logic       reset,
  input  logic       PS2CLK,
  input  logic       PS2DATA,
  input  logic [9:0] posicionJugador,
  input  logic [9:0] posicionEnemigo1,
  input  logic [9:0] posicionEnemigo2,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       blank,
  output logic       clkVGA,
  output logic [7:0] LED,
  output logic [1:0] LED2,
  output logic       KEY_COUNTER,
  output logic       freq_1Hz
);

  // ---------------------------------------------------------------- PS/2 and key decoder
  logic [7:0] rx_byte;
  logic       rx_valid;

  ps2_rx #(
    .Timeout(PS2_TIMEOUT)
  ) u_ps2_rx (
    .clk_i     (FPGACLK),
    .rst_ni    (reset),
    .ps2_clk_i (PS2CLK),
    .ps2_data_i(PS2DATA),
    .data_o    (rx_byte),
    .valid_o   (rx_valid)
  );

  key_state_e key_q, key_d;
  logic [1:0] led2_q, led2_d;
  logic [7:0] led_q;
  logic       key_cnt_q;

  always_comb begin
    key_d  = key_q;
    led2_d = led2_q;
    if (rx_valid) begin
      key_d = KeyIdle;
      if (rx_byte == ScanExt && key_q == KeyIdle) begin
        key_d = KeyExt;
      end else if (rx_byte == ScanBreak && key_q != KeyBreak) begin
        key_d = KeyBreak;
      end else if (key_q == KeyBreak) begin
        // Release only clears the steering if it names the key currently held
        if ((rx_byte == ScanRight && led2_q == Led2Right) ||
            (rx_byte == ScanLeft && led2_q == Led2Left)) begin
          led2_d = Led2None;
        end
      end else if (rx_byte == ScanRight) begin
        led2_d = Led2Right;
      end else if (rx_byte == ScanLeft) begin
        led2_d = Led2Left;
      end
    end
  end

  always_ff @(posedge FPGACLK or negedge reset) begin
    if (!reset) begin
      key_q     <= KeyIdle;
      led2_q    <= Led2None;
      led_q     <= '0;
      key_cnt_q <= 1'b0;
    end else begin
      key_q  <= key_d;
      led2_q <= led2_d;
      if (rx_valid) begin
        led_q     <= rx_byte;
        key_cnt_q <= ~key_cnt_q;
      end
    end
  end

  // ---------------------------------------------------------------- VGA timing and pixels
  logic        clk_vga_q;
  logic [9:0]  h_q, v_q;
  logic        hsync_q, vsync_q, blank_q;
  logic [23:0] rgb_q, rgb_d;
  logic        visible;
  logic        h_wrap, v_wrap;
  logic [10:0] px, py;

  assign h_wrap  = (h_q == HTotal - 10'd1);
  assign v_wrap  = (v_q == VTotal - 10'd1);
  assign visible = (h_q < HVisible) && (v_q < VVisible);
  assign px      = {1'b0, h_q};
  assign py      = {1'b0, v_q};

  always_comb begin
    rgb_d = '0;
    if (visible) begin
      if (in_span(px, {1'b0, posicionJugador}, CarW) && in_span(py, PlayerY, CarH)) begin
        rgb_d = ColPlayer;
      end else if (in_span(px, Enemy1X, CarW) &&
                   in_span(py, {1'b0, posicionEnemigo1}, CarH)) begin
        rgb_d = ColEnemy1;
      end else if (in_span(px, Enemy2X, CarW) &&
                   in_span(py, {1'b0, posicionEnemigo2}, CarH)) begin
        rgb_d = ColEnemy2;
      end else if (in_span(px, RoadX, RoadW)) begin
        rgb_d = ColRoad;
      end else begin
        rgb_d = ColGrass;
      end
    end
  end

  // Pixel tick is the FPGACLK cycle on which clkVGA rises
  always_ff @(posedge FPGACLK or negedge reset) begin
    if (!reset) begin
      clk_vga_q <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_q   <= 1'b0;
      rgb_q     <= '0;
    end else begin
      clk_vga_q <= ~clk_vga_q;
      if (!clk_vga_q) begin
        h_q <= h_wrap ? 10'd0 : h_q + 10'd1;
        if (h_wrap) begin
          v_q <= v_wrap ? 10'd0 : v_q + 10'd1;
        end
        hsync_q <= ~((h_q >= HSyncStart) && (h_q < HSyncEnd));
        vsync_q <= ~((v_q >= VSyncStart) && (v_q < VSyncEnd));
        blank_q <= visible;
        rgb_q   <= rgb_d;
      end
    end
  end

  // ---------------------------------------------------------------- 1 Hz divider
  localparam int unsigned DivMax = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 - 1 : 0;
  localparam int unsigned DivW   = (DivMax > 0) ? $clog2(DivMax + 1) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DivMax);

  logic [DivW-1:0] div_q;
  logic            freq_q;

  always_ff @(posedge FPGACLK or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      freq_q <= 1'b0;
    end else if (div_q == DivLast) begin
      div_q  <= '0;
      freq_q <= ~freq_q;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];
  assign clkVGA      = clk_vga_q;
  assign LED         = led_q;
  assign LED2        = led2_q;
  assign KEY_COUNTER = key_cnt_q;
  assign freq_1Hz    = freq_q;

endmodule

// File: tb/tb_racer_io_frontend.sv
// Directed bench for racer_io_frontend: PS/2 key decoding, VGA timing and pixels, divider.
module tb_racer_io_frontend;

  logic       FPGACLK = 1'b0;
  logic       reset = 1'b0;
  logic       PS2CLK = 1'b1;
  logic       PS2DATA = 1'b1;
  logic [9:0] posicionJugador = 10'd200;
  logic [9:0] posicionEnemigo1 = 10'd10;
  logic [9:0] posicionEnemigo2 = 10'd0;
  logic       hsync, vsync, blank, clkVGA, KEY_COUNTER, freq_1Hz;
  logic [7:0] red, green, blue, LED;
  logic [1:0] LED2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic exp_kc = 1'b0;

  racer_io_frontend #(
    .CLK_HZ     (10),
    .PS2_TIMEOUT(1000)
  ) dut (
    .FPGACLK         (FPGACLK),
    .reset           (reset),
    .PS2CLK          (PS2CLK),
    .PS2DATA         (PS2DATA),
    .posicionJugador (posicionJugador),
    .posicionEnemigo1(posicionEnemigo1),
    .posicionEnemigo2(posicionEnemigo2),
    .hsync           (hsync),
    .vsync           (vsync),
    .red             (red),
    .green           (green),
    .blue            (blue),
    .blank           (blank),
    .clkVGA          (clkVGA),
    .LED             (LED),
    .LED2            (LED2),
    .KEY_COUNTER     (KEY_COUNTER),
    .freq_1Hz        (freq_1Hz)
  );

  always #5 FPGACLK = ~FPGACLK;

  // Rising edges since the last reset release
  always @(posedge FPGACLK or negedge reset) begin
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge FPGACLK);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      PS2DATA = bits[i];
      repeat (10) @(negedge FPGACLK);
      PS2CLK = 1'b0;
      repeat (20) @(negedge FPGACLK);
      PS2CLK = 1'b1;
      repeat (10) @(negedge FPGACLK);
    end
    PS2DATA = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    send_bits(f, 11);
    repeat (20) @(negedge FPGACLK);
  endtask

  task automatic test_key_make;
    send_byte(8'hE0, 1'b0, 1'b0);
    exp_kc = ~exp_kc;
    vectors++;
    if (KEY_COUNTER !== exp_kc || LED !== 8'hE0) begin
      miscompares++;
      $display("FAIL make_e0: LED=%h KC=%b, want LED=e0 KC=%b", LED, KEY_COUNTER, exp_kc);
    end
    send_byte(8'h74, 1'b0, 1'b0);
    exp_kc = ~exp_kc;
    vectors++;
    if (LED !== 8'h74 || LED2 !== 2'b11 || KEY_COUNTER !== exp_kc) begin
      miscompares++;
      $display("FAIL make_right: LED=%h LED2=%b KC=%b, want 74 11 %b", LED, LED2, KEY_COUNTER,
               exp_kc);
    end
  endtask

  task automatic test_key_break;
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h74, 1'b0, 1'b0);
    exp_kc = ~exp_kc;
    vectors++;
    if (LED !== 8'h74 || LED2 !== 2'b00 || KEY_COUNTER !== exp_kc) begin
      miscompares++;
      $display("FAIL break_right: LED=%h LED2=%b KC=%b, want 74 00 %b", LED, LED2, KEY_COUNTER,
               exp_kc);
    end
  endtask

  task automatic test_key_left;
    send_byte(8'h6B, 1'b0, 1'b0);
    exp_kc = ~exp_kc;
    vectors++;
    if (LED !== 8'h6B || LED2 !== 2'b10 || KEY_COUNTER !== exp_kc) begin
      miscompares++;
      $display("FAIL make_left: LED=%h LED2=%b KC=%b, want 6b 10 %b", LED, LED2, KEY_COUNTER,
               exp_kc);
    end
  endtask

  task automatic test_last_wins;
    send_byte(8'h74, 1'b0, 1'b0);
    vectors++;
    if (LED2 !== 2'b11) begin
      miscompares++;
      $display("FAIL last_make: LED2=%b want 11", LED2);
    end
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h6B, 1'b0, 1'b0);
    vectors++;
    if (LED2 !== 2'b11 || LED !== 8'h6B) begin
      miscompares++;
      $display("FAIL break_not_held: LED2=%b LED=%h want 11 6b", LED2, LED);
    end
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h74, 1'b0, 1'b0);
    exp_kc = exp_kc ^ 1'b1;  // five accepted bytes in this task
    vectors++;
    if (LED2 !== 2'b00 || KEY_COUNTER !== exp_kc) begin
      miscompares++;
      $display("FAIL break_held: LED2=%b KC=%b want 00 %b", LED2, KEY_COUNTER, exp_kc);
    end
  endtask

  task automatic test_bad_frames;
    logic [7:0] exp_led;
    logic [1:0] exp_led2;
    send_byte(8'h12, 1'b0, 1'b0);
    exp_kc = ~exp_kc;
    vectors++;
    if (LED !== 8'h12 || KEY_COUNTER !== exp_kc) begin
      miscompares++;
      $display("FAIL plain_byte: LED=%h KC=%b want 12 %b", LED, KEY_COUNTER, exp_kc);
    end
    send_byte(8'h74, 1'b1, 1'b0);
`ifdef RACER_PS2_PARITY_EN
    exp_led  = 8'h12;
    exp_led2 = 2'b00;
`else
    exp_led  = 8'h74;
    exp_led2 = 2'b11;
    exp_kc   = ~exp_kc;
`endif
    vectors++;
    if (LED !== exp_led || LED2 !== exp_led2 || KEY_COUNTER !== exp_kc) begin
      miscompares++;
      $display("FAIL bad_parity: LED=%h LED2=%b KC=%b want %h %b %b", LED, LED2, KEY_COUNTER,
               exp_led, exp_led2, exp_kc);
    end
    send_byte(8'h29, 1'b0, 1'b1);
    vectors++;
    if (LED !== exp_led || KEY_COUNTER !== exp_kc) begin
      miscompares++;
      $display("FAIL bad_stop: LED=%h KC=%b want %h %b", LED, KEY_COUNTER, exp_led, exp_kc);
    end
  endtask

  task automatic test_timeout;
    send_bits(11'b1_0_0000_0000, 4);
    repeat (1100) @(negedge FPGACLK);
    send_byte(8'h6B, 1'b0, 1'b0);
    exp_kc = ~exp_kc;
    vectors++;
    if (LED !== 8'h6B || KEY_COUNTER !== exp_kc) begin
      miscompares++;
      $display("FAIL timeout: LED=%h KC=%b want 6b %b", LED, KEY_COUNTER, exp_kc);
    end
  endtask

  task automatic test_reset;
    send_bits(11'b1_1_1111_1110, 5);
    reset = 1'b0;
    repeat (3) @(negedge FPGACLK);
    vectors++;
    if (hsync !== 1'b1 || vsync !== 1'b1 || blank !== 1'b0 || {red, green, blue} !== 24'h0 ||
        clkVGA !== 1'b0 || LED !== 8'h00 || LED2 !== 2'b00 || KEY_COUNTER !== 1'b0 ||
        freq_1Hz !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: hs=%b vs=%b bl=%b rgb=%h cv=%b LED=%h LED2=%b KC=%b f=%b",
               hsync, vsync, blank, {red, green, blue}, clkVGA, LED, LED2, KEY_COUNTER,
               freq_1Hz);
    end
    exp_kc = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_after_release;
    wait_cyc(1);
    vectors++;
    if (clkVGA !== 1'b1 || blank !== 1'b1 || {red, green, blue} !== 24'h00A000) begin
      miscompares++;
      $display("FAIL first_pixel: clkVGA=%b blank=%b rgb=%h want 1 1 00a000", clkVGA, blank,
               {red, green, blue});
    end
    wait_cyc(2);
    vectors++;
    if (clkVGA !== 1'b0) begin
      miscompares++;
      $display("FAIL clkvga_toggle: clkVGA=%b want 0", clkVGA);
    end
    wait_cyc(4);
    vectors++;
    if (freq_1Hz !== 1'b0) begin
      miscompares++;
      $display("FAIL div_early: freq=%b want 0 at cycle 4", freq_1Hz);
    end
    wait_cyc(5);
    vectors++;
    if (freq_1Hz !== 1'b1) begin
      miscompares++;
      $display("FAIL div_first: freq=%b want 1 at cycle 5", freq_1Hz);
    end
  endtask

  task automatic test_mid_frame_discard;
    send_byte(8'h74, 1'b0, 1'b0);
    exp_kc = ~exp_kc;
    vectors++;
    if (LED !== 8'h74 || LED2 !== 2'b11 || KEY_COUNTER !== exp_kc) begin
      miscompares++;
      $display("FAIL mid_frame_reset: LED=%h LED2=%b KC=%b want 74 11 %b", LED, LED2,
               KEY_COUNTER, exp_kc);
    end
  endtask

  task automatic test_vga_timing;
    int t_fall, t_rise, t_next;
    wait_cyc(1280);
    vectors++;
    if (blank !== 1'b1) begin
      miscompares++;
      $display("FAIL blank_h639: blank=%b want 1", blank);
    end
    wait_cyc(1281);
    vectors++;
    if (blank !== 1'b0 || {red, green, blue} !== 24'h0) begin
      miscompares++;
      $display("FAIL blank_h640: blank=%b rgb=%h want 0 000000", blank, {red, green, blue});
    end
    while (hsync === 1'b1 && cyc < 2000) @(negedge FPGACLK);
    t_fall = cyc;
    while (hsync === 1'b0 && cyc < 2200) @(negedge FPGACLK);
    t_rise = cyc;
    while (hsync === 1'b1 && cyc < 3500) @(negedge FPGACLK);
    t_next = cyc;
    vectors++;
    if (t_fall != 1313) begin
      miscompares++;
      $display("FAIL hsync_first_fall: cycle %0d want 1313", t_fall);
    end
    vectors++;
    if (t_rise - t_fall != 192) begin
      miscompares++;
      $display("FAIL hsync_width: %0d cycles want 192", t_rise - t_fall);
    end
    vectors++;
    if (t_next - t_fall != 1600) begin
      miscompares++;
      $display("FAIL hsync_period: %0d cycles want 1600", t_next - t_fall);
    end
  endtask

  task automatic test_pixels;
    int ph [16];
    int pv [16];
    logic [23:0] pc [16];
    ph = '{359, 360, 399, 400, 99, 100, 539, 540, 170, 50, 159, 170, 199, 200, 210, 639};
    pv = '{2, 2, 2, 2, 3, 3, 3, 3, 9, 10, 10, 10, 10, 10, 12, 12};
    pc = '{24'h404040, 24'hFFFF00, 24'hFFFF00, 24'h404040, 24'h00A000, 24'h404040,
           24'h404040, 24'h00A000, 24'h404040, 24'h00A000, 24'h404040, 24'h0000FF,
           24'h0000FF, 24'h404040, 24'h404040, 24'h00A000};
    for (int i = 0; i < 16; i++) begin
      wait_cyc(2 * (pv[i] * 800 + ph[i]) + 1);
      vectors++;
      if ({red, green, blue} !== pc[i] || blank !== 1'b1) begin
        miscompares++;
        $display("FAIL pixel(%0d,%0d): rgb=%h blank=%b want %h 1", ph[i], pv[i],
                 {red, green, blue}, blank, pc[i]);
      end
    end
  endtask

  task automatic test_position_change;
    wait_cyc(2 * (12 * 800 + 700) + 1);
    vectors++;
    if ({red, green, blue} !== 24'h0 || blank !== 1'b0) begin
      miscompares++;
      $display("FAIL pixel(700,12): rgb=%h blank=%b want 000000 0", {red, green, blue}, blank);
    end
    posicionEnemigo1 = 10'd100;
    wait_cyc(2 * (13 * 800 + 170) + 1);
    vectors++;
    if ({red, green, blue} !== 24'h404040) begin
      miscompares++;
      $display("FAIL enemy_moved_away: rgb=%h want 404040", {red, green, blue});
    end
    posicionEnemigo1 = 10'd14;
    wait_cyc(2 * (14 * 800 + 170) + 1);
    vectors++;
    if ({red, green, blue} !== 24'h0000FF) begin
      miscompares++;
      $display("FAIL enemy_moved_in: rgb=%h want 0000ff", {red, green, blue});
    end
    wait_cyc(2 * (15 * 800) + 1);
    vectors++;
    if (vsync !== 1'b1 || hsync !== 1'b1) begin
      miscompares++;
      $display("FAIL sync_line15: vsync=%b hsync=%b want 1 1", vsync, hsync);
    end
  endtask

  task automatic test_divider;
    int t0, t1, t2;
    logic prev;
    prev = freq_1Hz;
    t0 = cyc;
    while (freq_1Hz === prev && cyc < t0 + 20) @(negedge FPGACLK);
    t1 = cyc;
    prev = freq_1Hz;
    while (freq_1Hz === prev && cyc < t1 + 20) @(negedge FPGACLK);
    t2 = cyc;
    vectors++;
    if (t2 - t1 != 5) begin
      miscompares++;
      $display("FAIL divider_half_period: %0d cycles want 5", t2 - t1);
    end
  endtask

  initial begin
    repeat (3) @(negedge FPGACLK);
    reset = 1'b1;
    repeat (5) @(negedge FPGACLK);
    test_key_make();
    test_key_break();
    test_key_left();
    test_last_wins();
    test_bad_frames();
    test_timeout();
    test_reset();
    test_after_release();
    test_mid_frame_discard();
    test_vga_timing();
    test_pixels();
    test_position_change();
    test_divider();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/racer_io_frontend.md
# racer_io_frontend

PS/2 keyboard receiver, 640×480@60 VGA sprite renderer and 1 Hz square-wave divider for the street-racing game, merged into one I/O front end. It sits between the board pins and the game processor. Steering is decoded from arrow-key scan codes. The processor's player and enemy positions are drawn as coloured rectangles over a road background. A 1 Hz timebase is provided for enemy motion.

## Interface
- CLK_HZ, 50_000_000: FPGACLK frequency.
- PS2_TIMEOUT, 5000: idle FPGACLK cycles after which a partial PS/2 frame is discarded.
- FPGACLK  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- PS2CLK, PS2DATA  in  1 each  raw PS/2 lines, asynchronous to FPGACLK.
- posicionJugador  in  10  player car left x (pixels).
- posicionEnemigo1, posicionEnemigo2  in  10  enemy top y (pixels).
- hsync, vsync  out  1  active-low syncs.
- red, green, blue  out  8 each  pixel colour.
- blank  out  1  active-low blanking: 1 in visible area, 0 otherwise.
- clkVGA  out  1  pixel clock, FPGACLK/2.
- LED  out  8  last accepted scan-code byte.
- LED2  out  2  steering: 2'b11 right held, 2'b10 left held, 2'b00 none.
- KEY_COUNTER  out  1  toggles on every accepted byte.
- freq_1Hz  out  1  1 Hz square wave, 50 % duty.

## Operation
- PS/2 input path:
  - Two-flop synchronisers on PS2CLK and PS2DATA. A falling edge of the synchronised PS2CLK samples the data line.
  - Frame format: start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
  - A frame is accepted when start = 0, stop = 1 and the parity check passes (see Configuration).
  - On acceptance: LED <= byte and KEY_COUNTER toggles.
  - A bad frame is dropped; no output changes.
- Key state machine, states IDLE, EXT, BREAK:
  - IDLE: E0 goes to EXT; F0 goes to BREAK.
  - EXT: F0 goes to BREAK.
  - Any other byte returns to IDLE.
  - Make code 0x74 sets LED2 = 11; make code 0x6B sets LED2 = 10. The E0 prefix is optional for both.
  - Break of 0x74 or 0x6B clears LED2 to 00, but only if that key is the one currently held.
  - The last make code wins.
- Timeout: if no PS2CLK falling edge occurs for PS2_TIMEOUT cycles, the bit counter resets to 0.
- VGA timing:
  - clkVGA toggles every FPGACLK cycle. Counters advance on the cycle where clkVGA goes 0→1.
  - Horizontal: total 800; visible 0–639; sync low at 656–751.
  - Vertical: total 525; visible 0–479; sync low at 490–491. v increments when h wraps 799→0.
- Colour priority, visible area only; rgb = 0 outside the visible area:
  1. Player: x in [posicionJugador, +40), y in [400, 460): FF0000.
  2. Enemy1: x in [160, 200), y in [posicionEnemigo1, +60): 0000FF.
  3. Enemy2: x in [360, 400), y in [posicionEnemigo2, +60): FFFF00.
  4. Road: x in [100, 540): 404040.
  5. Otherwise grass: 00A000.
- Rectangle bounds are computed 11 bits wide, so position + size never wraps.
- Divider: a counter counts to CLK_HZ/2−1, then clears and toggles freq_1Hz.

## Timing
- Reset values: hsync = vsync = 1; blank = 0; rgb = 0; clkVGA = 0; LED = 0; LED2 = 00; KEY_COUNTER = 0; freq_1Hz = 0. All counters and the FSM return to 0/IDLE.
- All outputs are registered. hsync, vsync, blank and rgb update together, one pixel after the counter value they decode.
- The LED/LED2/KEY_COUNTER update lands 3 FPGACLK cycles after the synchronised falling edge of the stop bit.
- A reset mid-frame discards the partial byte.
- Position inputs are sampled every pixel with no latching. Changes mid-frame show immediately.

## Configuration
- RACER_PS2_PARITY_EN defined: a frame with even parity is dropped.
- RACER_PS2_PARITY_EN undefined: the parity bit is ignored; only start and stop bits are checked.

## Structure
- Package racer_pkg holds:
  - VGA timing constants;
  - sprite sizes and lane x positions;
  - colour constants;
  - scan codes (E0, F0, 74, 6B);
  - the key-FSM state enum.
- Sub-module ps2_rx: synchroniser, bit shifter, timeout and frame check; outputs a byte and a valid pulse. Key FSM, VGA and divider live in the top.

## Test plan
- Reset asserted low mid-operation → all outputs at their reset values; after release, first hsync falls 2×656 cycles later.
- Frames E0, 74 at a ~15 kHz PS2CLK → LED = 0x74, LED2 = 11, KEY_COUNTER toggled twice.
- Then E0, F0, 74 → LED2 = 00. Frame 6B → LED2 = 10.
- Byte 0x74 sent with even parity, macro defined → no change. Same byte, macro undefined → accepted.
- VGA: hsync period 1600 cycles with 192 low; vsync low for 2 lines per 525; blank low at h = 640.
- posicionJugador = 200, enemies = 100 and 300 → pixel (210, 420) = FF0000; (170, 120) = 0000FF; (50, 10) = 00A000.
- CLK_HZ = 10 → freq_1Hz toggles every 5 cycles.
